// File: rtl/clkdiv_prog.sv
// -----------------------------------------------------------------------------
// clkdiv_prog
//   Programmable even-ratio clock divider with glitch-free gated channels.
//   Ratio = 2*(div_q+1); the divisor can be reloaded while running, and each
//   channel enable is synchronised and only takes effect during the low phase.
//
// Ports
//   clk         source clock (after the osc/JTAG clock mux)
//   rst_n       asynchronous reset, active-low
//   i_en        divider run enable (level, clk domain)
//   i_div       half-period minus one, captured when i_div_vld=1
//   i_div_vld   one-cycle load request for i_div
//   i_ch_en     per-channel enable, asynchronous to clk
//   o_clk_div   divided clock (registered)
//   o_clk_ch    gated divided clocks (registered)
//   o_ch_on     effective (synchronised, phase-aligned) channel enables
//   o_tick      one-cycle pulse on the first cycle of each o_clk_div high phase
//   o_div_ack   one-cycle pulse on the cycle a new divisor takes effect
// -----------------------------------------------------------------------------
module clkdiv_prog #(
    parameter int                 CNT_W       = 8,
    parameter int                 N_CH        = 3,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0]   DIV_RST     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [CNT_W-1:0]  i_div,
    input  logic              i_div_vld,
    input  logic [N_CH-1:0]   i_ch_en,
    output logic              o_clk_div,
    output logic [N_CH-1:0]   o_clk_ch,
    output logic [N_CH-1:0]   o_ch_on,
    output logic              o_tick,
    output logic              o_div_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                       r_state;
    logic [CNT_W-1:0]                 r_cnt;
    logic [CNT_W-1:0]                 r_div_q;
    logic [CNT_W-1:0]                 r_shadow;
    logic                             r_pend;
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
    logic [N_CH-1:0]                  r_en_eff;
    logic                             r_clk_div;
    logic [N_CH-1:0]                  r_clk_ch;
    logic                             r_tick;
    logic                             r_div_ack;

    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_div_next;
    logic              w_term;
    logic              w_fall;
    logic              w_apply;
    logic [N_CH-1:0]   w_sync_out;
    logic [N_CH-1:0]   w_en_eff_next;

    assign w_term     = (r_cnt == r_div_q);
    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_next   = r_clk_div;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_div_next = 1'b0;
                if (i_en) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!i_en && !r_clk_div) begin
                    // Stopping in the low phase: no pulse is cut short.
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    if (w_term) begin
                        w_cnt_next = '0;
                        w_div_next = ~r_clk_div;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                    // Disabled while high: finish the high phase first. If this
                    // is already its last cycle, the falling toggle ends it now.
                    if (!i_en) w_state_next = w_term ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_term) begin
                    w_cnt_next   = '0;
                    w_div_next   = 1'b0;
                    w_state_next = i_en ? S_RUN : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (i_en) w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_div_next   = 1'b0;
            end
        endcase
    end

    // A pending divisor is applied immediately when idle, otherwise only on the
    // falling toggle so that a high phase never mixes two divisors.
    assign w_fall  = r_clk_div & ~w_div_next;
    assign w_apply = r_pend & ((r_state == S_IDLE) | w_fall);

    // Channel enables may only change when the coming cycle is low.
    assign w_en_eff_next = w_div_next ? r_en_eff : w_sync_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_q   <= DIV_RST;
            r_shadow  <= '0;
            r_pend    <= 1'b0;
            r_sync    <= '0;
            r_en_eff  <= '0;
            r_clk_div <= 1'b0;
            r_clk_ch  <= '0;
            r_tick    <= 1'b0;
            r_div_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_clk_div <= w_div_next;
            r_tick    <= w_div_next & ~r_clk_div;

            if (i_div_vld) r_shadow <= i_div;
            // A load arriving on the apply cycle keeps pend set for the next fall.
            r_pend    <= i_div_vld | (r_pend & ~w_apply);
            if (w_apply) r_div_q <= r_shadow;
            r_div_ack <= w_apply;

            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_ch_en};
            r_en_eff  <= w_en_eff_next;
            r_clk_ch  <= {N_CH{w_div_next}} & w_en_eff_next;
        end
    end

    assign o_clk_div = r_clk_div;
    assign o_clk_ch  = r_clk_ch;
    assign o_ch_on   = r_en_eff;
    assign o_tick    = r_tick;
    assign o_div_ack = r_div_ack;

endmodule

// File: tb/tb_clkdiv_prog.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_prog
//   Directed, table-driven bench for clkdiv_prog (CNT_W=8, N_CH=3,
//   SYNC_STAGES=2, DIV_RST=0). Each table row holds the inputs applied before
//   a rising edge and the outputs expected just after it.
// -----------------------------------------------------------------------------
module tb_clkdiv_prog;

    logic       clk;
    logic       rst_n;
    logic       i_en;
    logic [7:0] i_div;
    logic       i_div_vld;
    logic [2:0] i_ch_en;
    logic       o_clk_div;
    logic [2:0] o_clk_ch;
    logic [2:0] o_ch_on;
    logic       o_tick;
    logic       o_div_ack;

    clkdiv_prog #(
        .CNT_W       (8),
        .N_CH        (3),
        .SYNC_STAGES (2),
        .DIV_RST     (8'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_div     (i_div),
        .i_div_vld (i_div_vld),
        .i_ch_en   (i_ch_en),
        .o_clk_div (o_clk_div),
        .o_clk_ch  (o_clk_ch),
        .o_ch_on   (o_ch_on),
        .o_tick    (o_tick),
        .o_div_ack (o_div_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       vld;
        logic [2:0] ch_en;
        logic       e_clk;
        logic       e_tick;
        logic       e_ack;
        logic [2:0] e_ch;
        logic [2:0] e_on;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;
    int   step;

    task automatic add(input logic en, input logic [7:0] div, input logic vld,
                       input logic [2:0] ch_en, input logic e_clk, input logic e_tick,
                       input logic e_ack, input logic [2:0] e_ch, input logic [2:0] e_on);
        vec_t v;
        v.en = en; v.div = div; v.vld = vld; v.ch_en = ch_en;
        v.e_clk = e_clk; v.e_tick = e_tick; v.e_ack = e_ack; v.e_ch = e_ch; v.e_on = e_on;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input logic e_clk, input logic e_tick, input logic e_ack,
                             input logic [2:0] e_ch, input logic [2:0] e_on);
        check("o_clk_div", {31'd0, o_clk_div}, {31'd0, e_clk});
        check("o_tick",    {31'd0, o_tick},    {31'd0, e_tick});
        check("o_div_ack", {31'd0, o_div_ack}, {31'd0, e_ack});
        check("o_clk_ch",  {29'd0, o_clk_ch},  {29'd0, e_ch});
        check("o_ch_on",   {29'd0, o_ch_on},   {29'd0, e_on});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step     = 0;

        // Ratio 2 with the reset divisor, then stop in the low phase.
        for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, (k % 2 == 0), (k % 2 == 0), 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);                     // 6
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);                     // 7
        // Load div=2 while idle: ack on the following cycle.
        add(0, 2, 1, 0, 0, 0, 0, 0, 0);                     // 8
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);                     // 9
        for (int k = 10; k <= 12; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);                     // 13 first rise
        add(1, 4, 1, 0, 1, 0, 0, 0, 0);                     // 14 load div=4 mid-high
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);                     // 15
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);                     // 16 fall + ack
        for (int k = 17; k <= 20; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);                     // 21
        add(1, 1, 1, 0, 1, 0, 0, 0, 0);                     // 22 load div=1 mid-high
        for (int k = 23; k <= 25; k++) add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);                     // 26 high stayed 5, ack
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);                     // 27
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);                     // 28
        add(1, 4, 1, 0, 1, 0, 0, 0, 0);                     // 29 load div=4
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);                     // 30
        for (int k = 31; k <= 34; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);                     // 35
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);                     // 36
        // Disable on the 2nd high cycle: high phase still lasts 5 cycles.
        for (int k = 37; k <= 39; k++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 40; k <= 44; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // div=3, then channel 1 enabled during a high phase.
        add(0, 3, 1, 0, 0, 0, 0, 0, 0);                     // 45
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);                     // 46
        for (int k = 47; k <= 50; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0);                     // 51
        for (int k = 52; k <= 54; k++) add(1, 0, 0, 3'b010, 1, 0, 0, 3'b000, 3'b000);
        for (int k = 55; k <= 58; k++) add(1, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b010);
        add(1, 0, 0, 3'b010, 1, 1, 0, 3'b010, 3'b010);      // 59
        for (int k = 60; k <= 62; k++) add(1, 0, 0, 3'b010, 1, 0, 0, 3'b010, 3'b010);
        for (int k = 63; k <= 66; k++) add(1, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b010);
        add(1, 0, 0, 3'b010, 1, 1, 0, 3'b010, 3'b010);      // 67
        add(1, 7, 1, 3'b010, 1, 0, 0, 3'b010, 3'b010);      // 68 pend=1 mid-high

        rst_n     = 1'b0;
        i_en      = 1'b0;
        i_div     = 8'd0;
        i_div_vld = 1'b0;
        i_ch_en   = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_all(0, 0, 0, 3'b000, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step      = k + 1;
            i_en      = vecs[k].en;
            i_div     = vecs[k].div;
            i_div_vld = vecs[k].vld;
            i_ch_en   = vecs[k].ch_en;
            @(posedge clk);
            #1;
            check_all(vecs[k].e_clk, vecs[k].e_tick, vecs[k].e_ack, vecs[k].e_ch, vecs[k].e_on);
        end

        // Reset mid-high with a divisor pending: outputs drop without a clock edge.
        step      = 100;
        i_div_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(0, 0, 0, 3'b000, 3'b000);
        i_en    = 1'b0;
        i_ch_en = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // The pending divisor must be discarded: no ack while idle.
        for (int k = 0; k < 3; k++) begin
            step = 101 + k;
            @(posedge clk);
            #1;
            check_all(0, 0, 0, 3'b000, 3'b000);
        end
        // div_q back to DIV_RST=0: ratio 2 after the RUN entry cycle.
        i_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step = 104 + k;
            @(posedge clk);
            #1;
            check_all(k % 2 == 1, k % 2 == 1, 0, 3'b000, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1);
    end

endmodule
